// File: rtl/jk_arb_pkg.sv
// ============================================================================
// Module      : jk_arb_pkg
// Description : Shared constants and types for the JK bank arbiter.
//               Command encoding is {j,k} and maps directly onto the
//               JK flip-flop inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_arb_pkg;

   // Per-bit command encoding, {j,k}
   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_RST  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_TGL  = 2'b11;

   // Arbiter FSM: IDLE means no grant this cycle, GNT means exactly one grant
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GNT  = 1'b1
   } arb_state_t;

endpackage : jk_arb_pkg

`default_nettype wire

// File: rtl/jk_bank_arbiter_if.sv
// ============================================================================
// Module      : jk_bank_arbiter_if
// Description : Requester-side bus of the JK bank arbiter. The master modport
//               is the requester view, the slave modport the arbiter view.
//               The lock vector exists only when JK_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jk_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(WIDTH)
);

   localparam int LIDW = $clog2(NREQ);

   // Requester -> arbiter
   logic [NREQ-1:0]      req;
   logic [2*NREQ-1:0]    cmd;
   logic [IDXW*NREQ-1:0] idx;
`ifdef JK_ARB_LOCK_EN
   logic [NREQ-1:0]      lock;
`endif

   // Arbiter -> requesters
   logic [NREQ-1:0]      gnt;
   logic                 busy;
   logic [LIDW-1:0]      last_id;
   logic [WIDTH-1:0]     q;
   logic [WIDTH-1:0]     q_bar;

`ifdef JK_ARB_LOCK_EN
   modport master (
      output req, cmd, idx, lock,
      input  gnt, busy, last_id, q, q_bar
   );

   modport slave (
      input  req, cmd, idx, lock,
      output gnt, busy, last_id, q, q_bar
   );
`else
   modport master (
      output req, cmd, idx,
      input  gnt, busy, last_id, q, q_bar
   );

   modport slave (
      input  req, cmd, idx,
      output gnt, busy, last_id, q, q_bar
   );
`endif

endinterface : jk_bank_arbiter_if

`default_nettype wire

// File: rtl/jk_ff_cell.sv
// ============================================================================
// Module      : jk_ff_cell
// Description : Single JK flip-flop storage bit with a clock enable and an
//               asynchronous active-low reset. q_bar is the exact complement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff_cell
   import jk_arb_pkg::*;
(
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic en,
   input  wire logic j,
   input  wire logic k,
   output logic      q,
   output logic      q_bar
);

   logic r_q;

   // JK update, only when enabled; reset clears the bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= 1'b0;
      end else if (en) begin
         case ({j, k})
            CMD_RST: r_q <= 1'b0;
            CMD_SET: r_q <= 1'b1;
            CMD_TGL: r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign q     = r_q;
   assign q_bar = ~r_q;

endmodule : jk_ff_cell

`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
// ============================================================================
// Module      : jk_bank_arbiter
// Description : Round-robin arbiter serialising per-bit JK commands from NREQ
//               requesters onto a bank of WIDTH jk_ff_cell bits, one command
//               per clock, each acknowledged with a one-cycle grant.
//               Optional owner lock enabled by the macro JK_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_bank_arbiter
   import jk_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  wire logic        clk,
   input  wire logic        reset,
   jk_bank_arbiter_if.slave bus
);

   localparam int LIDW = $clog2(NREQ);

   // Registered FSM state and outputs
   arb_state_t        r_state;
   logic [NREQ-1:0]   r_gnt;
   logic [LIDW-1:0]   r_last_id;

   // Arbitration
   logic [NREQ-1:0]   w_elig;
   logic              w_lock_hold;
   logic              w_found;
   logic [LIDW-1:0]   w_win;
   logic [LIDW-1:0]   w_cand;

   // Winner command decode
   logic [1:0]        w_cmd;
   logic [IDXW-1:0]   w_idx;
   logic              w_idx_ok;
   logic [WIDTH-1:0]  w_en;
   logic [WIDTH-1:0]  w_q;
   logic [WIDTH-1:0]  w_q_bar;

   // A requester being acknowledged this cycle sits out the next edge, so a
   // lone requester holding req high alternates grant / no-grant.
   assign w_elig = bus.req & ~r_gnt;

`ifdef JK_ARB_LOCK_EN
   // The current owner (the one holding gnt, which is always last_id) keeps
   // the bank while it holds both req and lock.
   assign w_lock_hold = r_gnt[r_last_id] & bus.req[r_last_id] & bus.lock[r_last_id];
`else
   assign w_lock_hold = 1'b0;
`endif

   // Round-robin search starting at last_id+1; scanning far-to-near leaves the
   // nearest eligible requester as the final assignment.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_last_id;
      w_cand  = '0;
      for (int o = NREQ; o >= 1; o--) begin
         w_cand = LIDW'((int'(r_last_id) + o) % NREQ);
         if (w_elig[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
      if (w_lock_hold) begin
         w_found = 1'b1;
         w_win   = r_last_id;
      end
   end

   // Select the winner's command and index; out-of-range indices drop the
   // command while the grant is still issued.
   assign w_cmd    = bus.cmd[2*int'(w_win) +: 2];
   assign w_idx    = bus.idx[IDXW*int'(w_win) +: IDXW];
   assign w_idx_ok = (32'(w_idx) < WIDTH);

   // FSM with registered grant and winner history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_last_id <= LIDW'(NREQ - 1);
      end else begin
         case (r_state)
            ST_IDLE, ST_GNT: begin
               if (w_found) begin
                  r_state   <= ST_GNT;
                  r_gnt     <= NREQ'(1) << w_win;
                  r_last_id <= w_win;
               end else begin
                  r_state   <= ST_IDLE;
                  r_gnt     <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

   // Index decode to per-cell enables and the storage bank itself
   generate
      for (genvar b = 0; b < WIDTH; b++) begin : g_cell
         assign w_en[b] = w_found & w_idx_ok & (32'(w_idx) == b);

         jk_ff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (w_en[b]),
            .j     (w_cmd[1]),
            .k     (w_cmd[0]),
            .q     (w_q[b]),
            .q_bar (w_q_bar[b])
         );
      end
   endgenerate

   assign bus.gnt     = r_gnt;
   assign bus.busy    = (r_state == ST_GNT);
   assign bus.last_id = r_last_id;
   assign bus.q       = w_q;
   assign bus.q_bar   = w_q_bar;

endmodule : jk_bank_arbiter

`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
// ============================================================================
// Module      : tb_jk_bank_arbiter
// Description : Directed self-checking bench for jk_bank_arbiter. IDXW is
//               widened to 4 so an out-of-range index (9) can be driven.
//               Lock scenario is included when JK_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_bank_arbiter;
   import jk_arb_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDXW  = 4;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   jk_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

   jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Clock: rising edges at 5, 15, 25, ...; checks happen on falling edges
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [1:0] c, input int i);
      bus.cmd[2*r +: 2]       = c;
      bus.idx[IDXW*r +: IDXW] = IDXW'(i);
      bus.req[r]              = 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      bus.req = '0;
      bus.cmd = '0;
      bus.idx = '0;
`ifdef JK_ARB_LOCK_EN
      bus.lock = '0;
`endif

      // Reset state
      step();
      check("rst_q",       32'(bus.q),       32'h00);
      check("rst_q_bar",   32'(bus.q_bar),   32'hFF);
      check("rst_gnt",     32'(bus.gnt),     32'h0);
      check("rst_busy",    32'(bus.busy),    32'h0);
      check("rst_last_id", 32'(bus.last_id), 32'h3);
      reset = 1'b1;

      // Requester 0 SET idx 3 held for three cycles: grant, gap, grant
      set_req(0, CMD_SET, 3);
      step();
      check("hold_gnt1", 32'(bus.gnt),     32'b0001);
      check("hold_busy1",32'(bus.busy),    32'h1);
      check("hold_q1",   32'(bus.q),       32'h08);
      check("hold_lid1", 32'(bus.last_id), 32'h0);
      step();
      check("hold_gnt2", 32'(bus.gnt),     32'b0000);
      check("hold_busy2",32'(bus.busy),    32'h0);
      step();
      check("hold_gnt3", 32'(bus.gnt),     32'b0001);
      check("hold_q3",   32'(bus.q),       32'h08);

      // Mid-cycle asynchronous reset with a grant in flight
      reset = 1'b0;
      #1;
      check("mid_rst_q",     32'(bus.q),       32'h00);
      check("mid_rst_q_bar", 32'(bus.q_bar),   32'hFF);
      check("mid_rst_gnt",   32'(bus.gnt),     32'h0);
      check("mid_rst_busy",  32'(bus.busy),    32'h0);
      check("mid_rst_lid",   32'(bus.last_id), 32'h3);
      bus.req = '0;
      step();
      reset = 1'b1;

      // Full contention, SET idx 0..3, each requester drops after its grant
      for (int r = 0; r < NREQ; r++) set_req(r, CMD_SET, r);
      for (int k = 0; k < NREQ; k++) begin
         step();
         check($sformatf("rr_gnt%0d", k), 32'(bus.gnt),     32'(1 << k));
         check($sformatf("rr_lid%0d", k), 32'(bus.last_id), 32'(k));
         bus.req[k] = 1'b0;
      end
      check("rr_q", 32'(bus.q), 32'h0F);

      // Steer last_id to 2, then raise 0 and 3 together: 3 first, then 0
      set_req(2, CMD_HOLD, 0);
      step();
      check("lid2_gnt", 32'(bus.gnt),     32'b0100);
      check("lid2_lid", 32'(bus.last_id), 32'h2);
      bus.req[2] = 1'b0;
      step();
      set_req(0, CMD_HOLD, 0);
      set_req(3, CMD_HOLD, 0);
      step();
      check("pair_gnt3", 32'(bus.gnt), 32'b1000);
      bus.req[3] = 1'b0;
      step();
      check("pair_gnt0", 32'(bus.gnt), 32'b0001);
      bus.req[0] = 1'b0;
      step();
      check("pair_idle", 32'(bus.gnt), 32'b0000);

      // Requester 1 TGL idx 7 twice, then SET idx 9 (out of range)
      set_req(1, CMD_TGL, 7);
      step();
      check("tgl_gnt1",   32'(bus.gnt),   32'b0010);
      check("tgl_q1",     32'(bus.q),     32'h8F);
      check("tgl_qbar1",  32'(bus.q_bar), 32'h70);
      step();
      check("tgl_gap",    32'(bus.gnt),   32'b0000);
      step();
      check("tgl_gnt2",   32'(bus.gnt),   32'b0010);
      check("tgl_q2",     32'(bus.q),     32'h0F);
      check("tgl_qbar2",  32'(bus.q_bar), 32'hF0);
      set_req(1, CMD_SET, 9);
      step();
      check("oor_gap",    32'(bus.gnt),   32'b0000);
      step();
      check("oor_gnt",    32'(bus.gnt),   32'b0010);
      check("oor_q",      32'(bus.q),     32'h0F);
      bus.req[1] = 1'b0;
      step();

`ifdef JK_ARB_LOCK_EN
      // Clear bit 0 first (last_id=1, so requester 3 is searched before 0)
      set_req(3, CMD_RST, 0);
      step();
      check("lk_pre_gnt", 32'(bus.gnt), 32'b1000);
      check("lk_pre_q",   32'(bus.q),   32'h0E);
      bus.req[3] = 1'b0;
      set_req(2, CMD_TGL, 0);
      bus.lock[2] = 1'b1;
      step();
      check("lk_gnt1", 32'(bus.gnt), 32'b0100);
      check("lk_q1",   32'(bus.q),   32'h0F);
      set_req(0, CMD_HOLD, 0);
      step();
      check("lk_gnt2", 32'(bus.gnt),     32'b0100);
      check("lk_q2",   32'(bus.q),       32'h0E);
      check("lk_lid2", 32'(bus.last_id), 32'h2);
      step();
      check("lk_gnt3", 32'(bus.gnt), 32'b0100);
      check("lk_q3",   32'(bus.q),   32'h0F);
      bus.lock[2] = 1'b0;
      step();
      check("lk_rel_gnt", 32'(bus.gnt), 32'b0001);
      check("lk_rel_q",   32'(bus.q),   32'h0F);
      bus.req = '0;
      step();
`endif

      step();
      check("end_busy", 32'(bus.busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_jk_bank_arbiter

`default_nettype wire
